// File: rtl/ca_gen_ctrl.sv
// 1D elementary cellular-automaton sequencer: seeds a row, applies an 8-bit Wolfram rule, and streams every cell to the frame buffer (optional CA_PAUSE_EN adds a pause input).
// Latency: first write COLS+1 cycles after start, then one cell per cycle while wr_ready stays high.
// Backpressure: wr_valid/wr_addr/wr_data hold until wr_ready; pause only withholds the next cell.
module ca_gen_ctrl #(
  parameter int COLS   = 640,
  parameter int ROWS   = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rule,
  input  logic              seed_sel,
  input  logic              wrap_en,
`ifdef CA_PAUSE_EN
  input  logic              pause,
`endif
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              busy,
  output logic              done,
  output logic [9:0]        row_cnt
);

  localparam int COL_W = $clog2(COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] CENTRE   = COL_W'(COLS / 2);
  localparam logic [9:0]       ROW_LAST = 10'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;

  state_t            state, state_nxt;
  logic [COL_W-1:0]  col;
  logic [7:0]        rule_q;
  logic              wrap_en_q, seed_sel_q;
  logic [15:0]       lfsr;
  logic              lfsr_fb;
  logic [COLS-1:0]   cur, nxt, nxt_upd;
  logic              left, right, cell_new;
  logic              hs, last_col, last_row, pause_now;

`ifdef CA_PAUSE_EN
  assign pause_now = pause;
`else
  assign pause_now = 1'b0;
`endif

  assign hs       = wr_valid & wr_ready;
  assign last_col = (col == COL_LAST);
  assign last_row = (row_cnt == ROW_LAST);
  assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign wr_data  = wr_valid & cur[col];

  // Neighbourhood lookup; edge neighbours come from the far end only when wrapping.
  always_comb begin
    left  = wrap_en_q & cur[COLS-1];
    right = wrap_en_q & cur[0];
    if (col != '0)
      left = cur[col - COL_W'(1)];
    if (col != COL_LAST)
      right = cur[col + COL_W'(1)];
    cell_new = rule_q[{left, cur[col], right}];
    nxt_upd = nxt;
    nxt_upd[col] = cell_new;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = SEED;
      SEED: if (last_col) state_nxt = RUN;
      RUN: begin
        if (hs && last_col && last_row) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col        <= '0;
      rule_q     <= '0;
      wrap_en_q  <= 1'b0;
      seed_sel_q <= 1'b0;
      lfsr       <= 16'hACE1;
      cur        <= '0;
      nxt        <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      row_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rule_q     <= rule;
            wrap_en_q  <= wrap_en;
            seed_sel_q <= seed_sel;
            col        <= '0;
          end
        end
        SEED: begin
          cur[col] <= seed_sel_q ? lfsr[0] : (col == CENTRE);
          lfsr     <= {lfsr_fb, lfsr[15:1]};
          if (last_col) begin
            col      <= '0;
            row_cnt  <= '0;
            wr_addr  <= '0;
            wr_valid <= !pause_now;
          end else begin
            col <= col + COL_W'(1);
          end
        end
        RUN: begin
          if (hs) begin
            nxt     <= nxt_upd;
            wr_addr <= wr_addr + ADDR_W'(1);
            if (last_col) begin
              col <= '0;
              cur <= nxt_upd;
              if (!last_row)
                row_cnt <= row_cnt + 10'd1;
            end else begin
              col <= col + COL_W'(1);
            end
            wr_valid <= !(last_col && last_row) && !pause_now;
          end else if (!wr_valid) begin
            // Paused: re-offer the held cell once pause releases.
            wr_valid <= !pause_now;
          end
        end
        default: wr_valid <= 1'b0;
      endcase
    end
  end

endmodule
